// File: rtl/heavy_part_stage.sv
// rtl/heavy_part_stage.sv - Elastic-sketch heavy-part stage: bucket RAM, read/compare/write-back pipeline, vote eviction
// Items are absorbed into their bucket or forwarded (incoming or evicted incumbent) through an output FIFO.

module heavy_part_stage #(
  parameter int                KEY_W   = 64,
  parameter int                CNT_W   = 32,
  parameter int                ADDR_W  = 12,
  parameter int                LAMBDA  = 8,
  parameter logic [ADDR_W-1:0] SEED    = '0,
  parameter int                FIFO_AW = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ip_addr_in_wr,
  input  logic [KEY_W+CNT_W-1:0] ip_addr_in,
  output logic                   ip_addr_in_alf,
  output logic                   ip_addr_value_out_wr,
  output logic [KEY_W+CNT_W-1:0] ip_addr_value_out,
  input  logic                   ip_addr_value_out_alf,
  output logic                   init_done
);

  localparam int IW     = KEY_W + CNT_W;
  localparam int CW     = CNT_W + 8;
  localparam int NCH    = (KEY_W + ADDR_W - 1) / ADDR_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int FDEPTH = 1 << FIFO_AW;
  localparam int FW     = FIFO_AW + 1;

  localparam logic [ADDR_W-1:0]  ADDR_ONE  = 1;
  localparam logic [ADDR_W-1:0]  ADDR_LAST = '1;
  localparam logic [FIFO_AW-1:0] PTR_ONE   = 1;
  localparam logic [FIFO_AW:0]   FILL_ONE  = 1;
  localparam logic [FIFO_AW:0]   FILL_FULL = FW'(FDEPTH);
  localparam logic [FIFO_AW:0]   FILL_ALF  = FW'(FDEPTH - 4);
  localparam logic [CW-1:0]      LAMBDA_W  = CW'(LAMBDA);

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [CNT_W-1:0] vpos;
    logic [CNT_W-1:0] vneg;
    logic             flag;
  } bucket_t;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  function automatic logic [ADDR_W-1:0] hash_idx(input logic [KEY_W-1:0] key);
    logic [NCH*ADDR_W-1:0] padded;
    logic [ADDR_W-1:0]     h;
    padded            = '0;
    padded[KEY_W-1:0] = key;
    h                 = SEED;
    for (int c = 0; c < NCH; c++) h = h ^ padded[c*ADDR_W +: ADDR_W];
    return h;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_addr_q, init_addr_d;

  logic                s1_vld_q, s1_vld_d;
  logic [KEY_W-1:0]    s1_key_q, s1_key_d;
  logic [CNT_W-1:0]    s1_cnt_q, s1_cnt_d;
  logic [ADDR_W-1:0]   s1_idx_q, s1_idx_d;

  logic                s2_vld_q, s2_vld_d;
  logic [KEY_W-1:0]    s2_key_q, s2_key_d;
  logic [CNT_W-1:0]    s2_cnt_q, s2_cnt_d;
  logic [ADDR_W-1:0]   s2_idx_q, s2_idx_d;
  bucket_t             s2_bkt_q, s2_bkt_d;

  logic                s3_vld_q, s3_vld_d;
  logic [ADDR_W-1:0]   s3_idx_q, s3_idx_d;
  bucket_t             s3_bkt_q, s3_bkt_d;
  logic                s4_vld_q, s4_vld_d;
  logic [ADDR_W-1:0]   s4_idx_q, s4_idx_d;
  bucket_t             s4_bkt_q, s4_bkt_d;

  logic [FIFO_AW-1:0]  fifo_wptr_q, fifo_wptr_d;
  logic [FIFO_AW-1:0]  fifo_rptr_q, fifo_rptr_d;
  logic [FIFO_AW:0]    fifo_fill_q, fifo_fill_d;
  logic                out_wr_q, out_wr_d;
  logic [IW-1:0]       out_data_q, out_data_d;

  bucket_t             table_mem [DEPTH];
  bucket_t             ram_rdata;
  logic [IW-1:0]       fifo_mem [FDEPTH];

  logic                run;
  logic [KEY_W-1:0]    in_key;
  logic [CNT_W-1:0]    in_cnt;
  logic [ADDR_W-1:0]   rd_addr;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  bucket_t             ram_wdata;
  bucket_t             cur;
  bucket_t             wr_bkt;
  logic [CNT_W-1:0]    nv;
  logic                evict;
  logic                fifo_push;
  logic                fifo_pop;
  logic [IW-1:0]       push_data;

  assign run     = (state_q == ST_RUN);
  assign in_key  = ip_addr_in[IW-1:CNT_W];
  assign in_cnt  = ip_addr_in[CNT_W-1:0];
  assign rd_addr = hash_idx(in_key);

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + ADDR_ONE;
      if (init_addr_q == ADDR_LAST) state_d = ST_RUN;
    end
  end

  always_comb begin
    s1_vld_d = ip_addr_in_wr && run;
    s1_key_d = in_key;
    s1_cnt_d = in_cnt;
    s1_idx_d = rd_addr;
    s2_vld_d = s1_vld_q && run;
    s2_key_d = s1_key_q;
    s2_cnt_d = s1_cnt_q;
    s2_idx_d = s1_idx_q;
    s2_bkt_d = ram_rdata;
  end

  // The RAM read for the S2 item missed the two most recent write-backs; the newer one wins.
  always_comb begin
    cur = s2_bkt_q;
    if (s3_vld_q && s3_idx_q == s2_idx_q)      cur = s3_bkt_q;
    else if (s4_vld_q && s4_idx_q == s2_idx_q) cur = s4_bkt_q;
    nv        = sat_add(cur.vneg, s2_cnt_q);
    evict     = {8'd0, nv} >= (LAMBDA_W * {8'd0, cur.vpos});
    wr_bkt    = cur;
    fifo_push = 1'b0;
    push_data = '0;
    if (s2_vld_q) begin
      if (cur.vpos == '0) begin
        wr_bkt = '{key: s2_key_q, vpos: s2_cnt_q, vneg: '0, flag: 1'b0};
      end else if (cur.key == s2_key_q) begin
        wr_bkt.vpos = sat_add(cur.vpos, s2_cnt_q);
      end else if (evict) begin
        fifo_push = 1'b1;
        push_data = {cur.key, cur.vpos};
        wr_bkt    = '{key: s2_key_q, vpos: s2_cnt_q, vneg: '0, flag: 1'b1};
      end else begin
        wr_bkt.vneg = nv;
        fifo_push   = 1'b1;
        push_data   = {s2_key_q, s2_cnt_q};
      end
    end
  end

  always_comb begin
    ram_we    = s2_vld_q;
    ram_waddr = s2_idx_q;
    ram_wdata = wr_bkt;
    if (!run) begin
      ram_we    = 1'b1;
      ram_waddr = init_addr_q;
      ram_wdata = '0;
    end
    s3_vld_d = s2_vld_q && run;
    s3_idx_d = s2_idx_q;
    s3_bkt_d = wr_bkt;
    s4_vld_d = s3_vld_q && run;
    s4_idx_d = s3_idx_q;
    s4_bkt_d = s3_bkt_q;
  end

  always_comb begin
    fifo_pop    = (fifo_fill_q != '0) && !ip_addr_value_out_alf;
    fifo_wptr_d = fifo_wptr_q;
    fifo_rptr_d = fifo_rptr_q;
    fifo_fill_d = fifo_fill_q;
    if (fifo_push) fifo_wptr_d = fifo_wptr_q + PTR_ONE;
    if (fifo_pop)  fifo_rptr_d = fifo_rptr_q + PTR_ONE;
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_fill_d = fifo_fill_q + FILL_ONE;
      2'b01:   fifo_fill_d = fifo_fill_q - FILL_ONE;
      default: fifo_fill_d = fifo_fill_q;
    endcase
    out_wr_d   = fifo_pop;
    out_data_d = fifo_pop ? fifo_mem[fifo_rptr_q] : '0;
  end

  // Read-first RAM: a write and a read to the same address on one edge returns the old bucket.
  always_ff @(posedge clk) begin
    if (ram_we) table_mem[ram_waddr] <= ram_wdata;
    ram_rdata <= table_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[fifo_wptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      s1_vld_q    <= 1'b0;
      s1_key_q    <= '0;
      s1_cnt_q    <= '0;
      s1_idx_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_key_q    <= '0;
      s2_cnt_q    <= '0;
      s2_idx_q    <= '0;
      s2_bkt_q    <= '0;
      s3_vld_q    <= 1'b0;
      s3_idx_q    <= '0;
      s3_bkt_q    <= '0;
      s4_vld_q    <= 1'b0;
      s4_idx_q    <= '0;
      s4_bkt_q    <= '0;
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
      fifo_fill_q <= '0;
      out_wr_q    <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      s1_vld_q    <= s1_vld_d;
      s1_key_q    <= s1_key_d;
      s1_cnt_q    <= s1_cnt_d;
      s1_idx_q    <= s1_idx_d;
      s2_vld_q    <= s2_vld_d;
      s2_key_q    <= s2_key_d;
      s2_cnt_q    <= s2_cnt_d;
      s2_idx_q    <= s2_idx_d;
      s2_bkt_q    <= s2_bkt_d;
      s3_vld_q    <= s3_vld_d;
      s3_idx_q    <= s3_idx_d;
      s3_bkt_q    <= s3_bkt_d;
      s4_vld_q    <= s4_vld_d;
      s4_idx_q    <= s4_idx_d;
      s4_bkt_q    <= s4_bkt_d;
      fifo_wptr_q <= fifo_wptr_d;
      fifo_rptr_q <= fifo_rptr_d;
      fifo_fill_q <= fifo_fill_d;
      out_wr_q    <= out_wr_d;
      out_data_q  <= out_data_d;
    end
  end

  assert property (@(posedge clk) disable iff (!reset) !(fifo_push && fifo_fill_q == FILL_FULL));

  assign ip_addr_in_alf       = !run || (fifo_fill_q >= FILL_ALF);
  assign ip_addr_value_out_wr = out_wr_q;
  assign ip_addr_value_out    = out_data_q;
  assign init_done            = run;

endmodule

// File: tb/tb_heavy_part_stage.sv
// tb/tb_heavy_part_stage.sv - self-checking bench for heavy_part_stage
// Small configuration (16-entry table, 8-bit votes, 8-deep FIFO) so every corner is reachable.

module tb_heavy_part_stage;

  localparam int         KEY_W   = 16;
  localparam int         CNT_W   = 8;
  localparam int         ADDR_W  = 4;
  localparam int         LAMBDA  = 2;
  localparam int         FIFO_AW = 3;
  localparam logic [3:0] SEED    = 4'h9;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        in_wr    = 1'b0;
  logic [23:0] in_data  = '0;
  logic        out_alf  = 1'b0;
  logic        in_alf;
  logic        out_wr;
  logic [23:0] out_data;
  logic        init_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [23:0] exp_q [$];

  typedef struct {
    logic [15:0] key;
    int          pos;
    int          neg;
  } mbkt_t;
  mbkt_t mt [16];

  typedef struct {
    logic [15:0] key;
    logic [7:0]  cnt;
    bit          fwd;
    logic [15:0] okey;
    logic [7:0]  ocnt;
  } vec_t;
  vec_t tbl [$];

  logic [15:0] pool [8];
  int          strobes [$];

  heavy_part_stage #(
    .KEY_W(KEY_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W),
    .LAMBDA(LAMBDA), .SEED(SEED), .FIFO_AW(FIFO_AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ip_addr_in_wr(in_wr),
    .ip_addr_in(in_data),
    .ip_addr_in_alf(in_alf),
    .ip_addr_value_out_wr(out_wr),
    .ip_addr_value_out(out_data),
    .ip_addr_value_out_alf(out_alf),
    .init_done(init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every output strobe must match the oldest outstanding expected item.
  always @(negedge clk) begin
    if (out_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h expected none (cycle %0d)", out_data, cyc);
      end else begin
        check("out_item", {8'h0, out_data}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  function automatic int midx(input logic [15:0] key);
    int h;
    h = int'(SEED);
    for (int c = 0; c < 4; c++) h = h ^ int'((key >> (4 * c)) & 16'h000F);
    return h;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mt[i] = '{16'h0, 0, 0};
  endtask

  task automatic model_apply(input logic [15:0] key, input logic [7:0] cnt);
    int i;
    int c;
    int nv;
    i = midx(key);
    c = int'(cnt);
    if (mt[i].pos == 0) begin
      mt[i] = '{key, c, 0};
    end else if (mt[i].key == key) begin
      mt[i].pos = (mt[i].pos + c > 255) ? 255 : mt[i].pos + c;
    end else begin
      nv = (mt[i].neg + c > 255) ? 255 : mt[i].neg + c;
      if (nv >= LAMBDA * mt[i].pos) begin
        exp_q.push_back({mt[i].key, 8'(mt[i].pos)});
        mt[i] = '{key, c, 0};
      end else begin
        mt[i].neg = nv;
        exp_q.push_back({key, cnt});
      end
    end
  endtask

  task automatic send(input logic [15:0] key, input logic [7:0] cnt);
    int w;
    w = 0;
    while (in_alf === 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_alf_timeout: got alf=1 for %0d cycles expected release", w);
    end else begin
      in_wr   = 1'b1;
      in_data = {key, cnt};
      @(negedge clk);
      in_wr   = 1'b0;
      in_data = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    in_wr   = 1'b0;
    in_data = '0;
    @(negedge clk);
    check("rst_out_wr", out_wr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_init_done", init_done, 0);
    check("rst_in_alf", in_alf, 1);
    @(negedge clk);
    exp_q.delete();
    model_clear();
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (k < 16)  check("alf_in_init", in_alf, 1);
      if (k == 15) check("init_done_early", init_done, 0);
      if (k == 16) check("init_done_16", init_done, 1);
    end
    @(negedge clk);
    check("alf_after_init", in_alf, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          fill_exp;
    int          sent;
    int          got;
    int          first;
    int          last;
    logic [15:0] k;
    logic [7:0]  c;

    pool = '{16'h0012, 16'h0021, 16'h0030, 16'h0100, 16'h0010, 16'h0001, 16'h0007, 16'h0070};
    do_reset();

    // Hand-derived vectors; keys in each group share one bucket, groups use distinct buckets.
    for (int i = 0; i < 5; i++) tbl.push_back('{16'h0012, 8'd1, 1'b0, 16'h0, 8'h0});
    tbl.push_back('{16'h0021, 8'd10, 1'b1, 16'h0012, 8'd5});
    tbl.push_back('{16'h0100, 8'd3, 1'b0, 16'h0, 8'h0});
    for (int i = 0; i < 5; i++) tbl.push_back('{16'h0010, 8'd1, 1'b1, 16'h0010, 8'd1});
    tbl.push_back('{16'h0010, 8'd1, 1'b1, 16'h0100, 8'd3});
    tbl.push_back('{16'h0010, 8'd1, 1'b0, 16'h0, 8'h0});
    tbl.push_back('{16'h0001, 8'd4, 1'b1, 16'h0010, 8'd2});
    tbl.push_back('{16'h0007, 8'd200, 1'b0, 16'h0, 8'h0});
    tbl.push_back('{16'h0007, 8'd100, 1'b0, 16'h0, 8'h0});
    tbl.push_back('{16'h0070, 8'd255, 1'b1, 16'h0070, 8'd255});
    foreach (tbl[i]) begin
      if (tbl[i].fwd) exp_q.push_back({tbl[i].okey, tbl[i].ocnt});
      send(tbl[i].key, tbl[i].cnt);
    end
    repeat (10) @(negedge clk);
    check("table_drained", exp_q.size(), 0);

    // Backpressure: downstream held off, mismatches streamed into one bucket.
    do_reset();
    out_alf = 1'b1;
    send(16'h0005, 8'd100);
    sent = 0;
    for (int t = 0; t < 20; t++) begin
      fill_exp = 0;
      foreach (strobes[j]) if (strobes[j] + 3 <= cyc) fill_exp++;
      check("alf_vs_fill", in_alf, (fill_exp >= 4) ? 1 : 0);
      check("held_no_pop", out_wr, 0);
      if (in_alf === 1'b0) begin
        k       = {sent[3:0] + 4'd1, sent[3:0] + 4'd1, 8'h05};
        in_wr   = 1'b1;
        in_data = {k, 8'd1};
        strobes.push_back(cyc);
        exp_q.push_back({k, 8'd1});
        sent++;
      end else begin
        in_wr = 1'b0;
      end
      @(negedge clk);
    end
    in_wr = 1'b0;
    check("bp_sent", sent, 6);
    out_alf = 1'b0;
    got   = 0;
    first = -1;
    last  = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (out_wr === 1'b1) begin
        got++;
        if (first < 0) first = t;
        last = t;
      end
    end
    check("drain_count", got, 6);
    check("drain_contiguous", last - first + 1, 6);
    check("drain_queue_empty", exp_q.size(), 0);
    check("alf_after_drain", in_alf, 0);

    // Mid-stream reset while the FIFO is popping.
    out_alf = 1'b1;
    for (int i = 0; i < 4; i++) begin
      k = {4'(i + 7), 4'(i + 7), 8'h05};
      exp_q.push_back({k, 8'd1});
      send(k, 8'd1);
    end
    repeat (4) @(negedge clk);
    out_alf = 1'b0;
    @(negedge clk);
    do_reset();
    send(16'h0012, 8'd1);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      check("post_reset_quiet", out_wr, 0);
    end
    check("post_reset_queue", exp_q.size(), 0);

    // Randomised traffic against the reference model.
    do_reset();
    for (int t = 0; t < 600; t++) begin
      out_alf = ($urandom_range(0, 3) == 0);
      if (in_alf === 1'b0 && $urandom_range(0, 3) != 0) begin
        k = ($urandom_range(0, 4) == 0) ? 16'($urandom) : pool[$urandom_range(0, 7)];
        c = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'($urandom_range(1, 6));
        in_wr   = 1'b1;
        in_data = {k, c};
        model_apply(k, c);
      end else begin
        in_wr = 1'b0;
      end
      @(negedge clk);
    end
    in_wr   = 1'b0;
    out_alf = 1'b0;
    for (int w = 0; w < 60 && exp_q.size() != 0; w++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("random_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
